// File: rtl/alu_exec_unit.sv
// EX-stage execution unit: single-cycle ALU ops plus an iterative shift-add
// multiplier that stalls the issue handshake until the product is ready.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ctrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [SH_W-1:0] CNT_LAST = SH_W'(WIDTH - 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_NOOP = 3'b110;
  localparam logic [2:0] OP_SRAI = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] mcand_p1;
  logic [WIDTH-1:0] mplier_p1;
  logic [WIDTH-1:0] acc_p1;
  logic [SH_W-1:0]  cnt_p1;
  logic [WIDTH-1:0] result_p1;
  logic             vld_p1;

  logic             accept;
  logic             mul_last;
  logic [WIDTH-1:0] acc_sum;

  // Single-cycle datapath; MUL never reaches here, it has its own iterator.
  function automatic logic [WIDTH-1:0] alu_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic signed [WIDTH-1:0] sa;
    logic [SH_W-1:0]         sh;
    sa = a;
    sh = b[SH_W-1:0];
    case (op)
      OP_AND:  alu_op = a & b;
      OP_XOR:  alu_op = a ^ b;
      OP_SLL:  alu_op = a << sh;
      OP_ADD:  alu_op = a + b;
      OP_SUB:  alu_op = a - b;
      OP_SRAI: alu_op = sa >>> sh;
      OP_NOOP: alu_op = '0;
      default: alu_op = '0;
    endcase
  endfunction

  assign accept   = start_i && (state == S_IDLE);
  assign mul_last = (state == S_MUL) && (cnt_p1 == CNT_LAST);
  assign acc_sum  = mplier_p1[0] ? (acc_p1 + mcand_p1) : acc_p1;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && ctrl_i == OP_MUL) state_nxt = S_MUL;
      S_MUL:  if (mul_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p1: accept edge latches operands / single-cycle result; MUL iterates here
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      mcand_p1  <= '0;
      mplier_p1 <= '0;
      acc_p1    <= '0;
      cnt_p1    <= '0;
      result_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (ctrl_i == OP_MUL) begin
              mcand_p1  <= data1_i;
              mplier_p1 <= data2_i;
              acc_p1    <= '0;
              cnt_p1    <= '0;
            end else begin
              result_p1 <= alu_op(ctrl_i, data1_i, data2_i);
              vld_p1    <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_p1    <= acc_sum;
          mcand_p1  <= mcand_p1 << 1;
          mplier_p1 <= mplier_p1 >> 1;
          cnt_p1    <= cnt_p1 + 1'b1;
          if (mul_last) begin
            result_p1 <= acc_sum;
            vld_p1    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o  = (state == S_IDLE);
  assign valid_o  = vld_p1;
  assign result_o = result_p1;
  assign zero_o   = (result_p1 == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: expected results and completion cycles are
// queued at issue and checked by an independent monitor on each valid_o.
module tb_alu_exec_unit;
  localparam int W = 32;

  localparam logic [2:0] AND_ = 3'b000, XOR_ = 3'b001, SLL_ = 3'b010, ADD_ = 3'b011;
  localparam logic [2:0] SUB_ = 3'b100, MUL_ = 3'b101, NOP_ = 3'b110, SRA_ = 3'b111;

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [2:0]   ctrl;
  logic [W-1:0] d1, d2;
  logic         ready, valid, zero;
  logic [W-1:0] result;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t e;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ctrl_i(ctrl),
    .data1_i(d1), .data2_i(d2), .ready_o(ready), .valid_o(valid),
    .result_o(result), .zero_o(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per valid_o and checks value, zero flag and cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_valid actual=none required=0x%08h at cycle %0d", q[0].res, q[0].cyc);
      void'(q.pop_front());
    end
    if (valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid actual=0x%08h required=no valid (cycle %0d)", result, cyc);
      end else begin
        e = q.pop_front();
        chk("result", result, e.res);
        chk("latency_cycle", W'(cyc), W'(e.cyc));
        chk("zero_flag", W'(zero), W'(e.res == '0));
      end
    end
  end

  // Called just after a negedge; returns at the next negedge (accept edge in between).
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input int lat, input bit push);
    exp_t t;
    ctrl  = op;
    d1    = a;
    d2    = b;
    start = 1'b1;
    if (push) begin
      t.res = exp;
      t.cyc = cyc + lat;
      q.push_back(t);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    rst = 1'b1; start = 1'b1; ctrl = ADD_; d1 = 1; d2 = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", W'(ready), 1);
    chk("reset_valid", W'(valid), 0);
    chk("reset_result", result, 0);
    chk("reset_zero", W'(zero), 1);
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_idle_valid", W'(valid), 0);

    // Back-to-back single-cycle ops, one per cycle
    issue(ADD_, 32'd7, 32'hFFFF_FFFD, 32'd4, 1, 1);
    issue(SUB_, 32'd5, 32'd5, 32'd0, 1, 1);
    issue(AND_, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1, 1);
    issue(XOR_, 32'h0000_FFFF, 32'h0000_0F0F, 32'h0000_F0F0, 1, 1);
    issue(NOP_, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1, 1);
    issue(SLL_, 32'd1, 32'd31, 32'h8000_0000, 1, 1);
    issue(SRA_, 32'h8000_0000, 32'd4, 32'hF800_0000, 1, 1);
    issue(SLL_, 32'd1, 32'h21, 32'd2, 1, 1);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // MUL with an ignored ADD presented while busy
    issue(MUL_, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, W + 1, 1);
    busy = 0;
    for (int i = 0; i < 40 && ready !== 1'b1; i++) begin
      if (i == 5) begin
        start = 1'b1; ctrl = ADD_; d1 = 1; d2 = 1;
      end else begin
        start = 1'b0;
      end
      busy++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("mul_ready_low_cycles", W'(busy), W'(W));
    repeat (3) @(negedge clk);

    // ADD then MUL issued in the cycle ADD completes
    issue(ADD_, 32'd2, 32'd3, 32'd5, 1, 1);
    issue(MUL_, 32'd6, 32'd7, 32'h2A, W + 1, 1);
    start = 1'b0;
    for (int i = 0; i < 40 && ready !== 1'b1; i++) begin
      chk("hold_result_during_mul", result, 32'd5);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);

    // Reset after 10 MUL iterations discards the operation
    issue(MUL_, 32'h0001_2345, 32'h10, 32'd0, 0, 0);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midmul_reset_ready", W'(ready), 1);
    chk("midmul_reset_valid", W'(valid), 0);
    chk("midmul_reset_result", result, 0);
    chk("midmul_reset_zero", W'(zero), 1);
    repeat (40) @(negedge clk);
    chk("midmul_no_valid", W'(valid), 0);
    issue(ADD_, 32'd1, 32'd1, 32'd2, 1, 1);
    start = 1'b0;

    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0 pending", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
